// File: rtl/dram_read_responder.sv
// DRAM timing/bandwidth model: queues tagged read requests and returns a deterministic
// address-derived data stream for each, in order, after a fixed access latency.
module dram_read_responder #(
    parameter int unsigned DRAM_LATENCY       = 10,
    parameter int unsigned BW_BYTES_PER_CYCLE = 16,
    parameter int unsigned MAX_OUTSTANDING    = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       req_valid,
    output logic                                       req_ready,
    input  logic [7:0]                                 req_tag,
    input  logic [31:0]                                req_addr,
    input  logic [31:0]                                req_length,
    output logic                                       rsp_valid,
    input  logic                                       rsp_ready,
    output logic [7:0]                                 rsp_tag,
    output logic [31:0]                                rsp_addr,
    output logic [BW_BYTES_PER_CYCLE*8-1:0]            rsp_data,
    output logic [$clog2(BW_BYTES_PER_CYCLE+1)-1:0]    rsp_bytes,
    output logic                                       rsp_last,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_count
);

    localparam int unsigned BYTES_W = $clog2(BW_BYTES_PER_CYCLE + 1);
    localparam int unsigned OCC_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned LAT_W   = $clog2(DRAM_LATENCY + 1);
    localparam int unsigned SHIFT   = $clog2(BW_BYTES_PER_CYCLE);
    localparam int unsigned LANES   = BW_BYTES_PER_CYCLE / 4;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(DRAM_LATENCY - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t             state, state_d;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_d;
    logic [OCC_W-1:0]   occ_d;
    logic [31:0]        beat_idx, beat_idx_d;
    logic [LAT_W-1:0]   lat_head_next;

    logic [7:0]         tag_q  [MAX_OUTSTANDING];
    logic [31:0]        addr_q [MAX_OUTSTANDING];
    logic [31:0]        len_q  [MAX_OUTSTANDING];
    logic [LAT_W-1:0]   lat_q  [MAX_OUTSTANDING];

    logic               push, beat_xfer, pop, head_last;
    logic [31:0]        head_len, beats_m1, addr_raw;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Head-of-queue beat geometry; the head stays in the queue until its last beat.
    assign head_len  = len_q[rd_ptr];
    assign beats_m1  = (head_len == 32'd0) ? 32'd0 : ((head_len - 32'd1) >> SHIFT);
    assign head_last = (beat_idx == beats_m1);
    assign addr_raw  = addr_q[rd_ptr] + (beat_idx << SHIFT);

    assign req_ready = (outstanding_count < OCC_W'(MAX_OUTSTANDING));
    assign push      = req_valid & req_ready;
    assign rsp_valid = (state == BURST);
    assign beat_xfer = rsp_valid & rsp_ready;
    assign pop       = beat_xfer & head_last;

    // Next-state: BURST whenever the head after this edge will have its latency elapsed.
    always_comb begin
        state_d       = IDLE;
        rd_ptr_d      = rd_ptr;
        wr_ptr_d      = wr_ptr;
        beat_idx_d    = beat_idx;
        occ_d         = outstanding_count + OCC_W'(push) - OCC_W'(pop);
        lat_head_next = '0;

        if (push) wr_ptr_d = ptr_inc(wr_ptr);
        if (beat_xfer) beat_idx_d = pop ? 32'd0 : beat_idx + 32'd1;
        if (pop) rd_ptr_d = ptr_inc(rd_ptr);

        if (push && (rd_ptr_d == wr_ptr)) begin
            lat_head_next = LAT_INIT;
        end else if (lat_q[rd_ptr_d] != '0) begin
            lat_head_next = lat_q[rd_ptr_d] - LAT_W'(1);
        end

        if ((occ_d != '0) && (lat_head_next == '0)) state_d = BURST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            outstanding_count <= '0;
            beat_idx          <= '0;
        end else begin
            state             <= state_d;
            rd_ptr            <= rd_ptr_d;
            wr_ptr            <= wr_ptr_d;
            outstanding_count <= occ_d;
            beat_idx          <= beat_idx_d;
        end
    end

    // Per-entry latency countdowns run independently so accesses overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) lat_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                if (push && (wr_ptr == PTR_W'(i))) begin
                    lat_q[i] <= LAT_INIT;
                end else if (lat_q[i] != '0) begin
                    lat_q[i] <= lat_q[i] - LAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_ptr]  <= req_tag;
            addr_q[wr_ptr] <= req_addr;
            len_q[wr_ptr]  <= req_length;
        end
    end

    // Response fields are zero whenever no beat is presented.
    assign rsp_tag   = rsp_valid ? tag_q[rd_ptr] : 8'd0;
    assign rsp_addr  = rsp_valid ? addr_raw : 32'd0;
    assign rsp_last  = rsp_valid & head_last;
    assign rsp_bytes = !rsp_valid ? '0 :
                       head_last  ? BYTES_W'(head_len - (beats_m1 << SHIFT)) :
                                    BYTES_W'(BW_BYTES_PER_CYCLE);

    for (genvar j = 0; j < int'(LANES); j++) begin : g_lane
        assign rsp_data[32*j +: 32] = rsp_valid ? (addr_raw + 32'(4 * j)) : 32'd0;
    end

endmodule
